// File: rtl/mrc_ec_pkg.sv
// Shared sign codes and modular-arithmetic helpers for the mixed-radix tail pipeline.
// mod_inverse is evaluated at elaboration; mod_mac backs the registered MAC stages.
package mrc_ec_pkg;

  localparam logic [1:0] SGN_ZERO = 2'b00;
  localparam logic [1:0] SGN_POS  = 2'b01;
  localparam logic [1:0] SGN_NEG  = 2'b10;
  localparam logic [1:0] SGN_ERR  = 2'b11;

  // Extended Euclid; returns a^-1 mod m, or 0 when a and m share a factor.
  function automatic longint mod_inverse(input longint a, input longint m);
    longint t_val;
    longint t_new;
    longint r_val;
    longint r_new;
    longint quo;
    longint tmp;
    t_val = 0;
    t_new = 1;
    r_val = m;
    r_new = a % m;
    while (r_new != 0) begin
      quo   = r_val / r_new;
      tmp   = t_val - quo * t_new;
      t_val = t_new;
      t_new = tmp;
      tmp   = r_val - quo * r_new;
      r_val = r_new;
      r_new = tmp;
    end
    if (r_val != 1) begin
      t_val = 0;
    end else if (t_val < 0) begin
      t_val = t_val + m;
    end
    return t_val;
  endfunction

  // Operands are below 2**31, so the 64-bit product never overflows.
  function automatic longint mod_mac(input longint a, input longint b,
                                     input longint c, input longint m);
    return (a * b + c) % m;
  endfunction

endpackage

// File: rtl/mrc_modmac_reg.sv
// Registered modular multiply-accumulate: q <= (a*b + c) mod MOD when en is high.
// The product is formed at full double width before reduction.
module mrc_modmac_reg
  import mrc_ec_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int MOD        = 262069
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] c,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] q_reg;
  logic [DATA_WIDTH-1:0] q_next;

  assign q_next = DATA_WIDTH'(mod_mac(longint'(a), longint'(b), longint'(c), longint'(MOD)));

  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg <= '0;
    end else if (en) begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/mrc_ec_tail_pipe.sv
// Final mixed-radix stages with redundant-digit sign/overflow detection.
// Three-stage pipeline under one global enable; a stalled output freezes every stage.
module mrc_ec_tail_pipe
  import mrc_ec_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int TAG_WIDTH  = 8,
  parameter int MOD_ACC    = 262069,
  parameter int MOD_R0     = 262091,
  parameter int MOD_R1     = 262103,
  parameter int PWR_R0     = 1,
  parameter int PWR_R1     = 1,
  parameter int POS_TH     = 131034,
  parameter int NEG_TH     = 131044
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] acc_in,
  input  logic [DATA_WIDTH-1:0] dig_r0,
  input  logic [DATA_WIDTH-1:0] dig_r1,
  input  logic [1:0]            sgn_in,
  input  logic [TAG_WIDTH-1:0]  tag_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] acc_out,
  output logic [1:0]            sgn_out,
  output logic [TAG_WIDTH-1:0]  tag_out
);

  localparam int INV    = int'(mod_inverse(longint'(MOD_R0), longint'(MOD_R1)));
  localparam int STAGES = 3;

  logic en;

  // Valid and tag travel through an identical shift chain.
  logic                 v_reg   [STAGES];
  logic [TAG_WIDTH-1:0] tag_reg [STAGES];

  logic signed [DATA_WIDTH:0] diff_s;
  logic signed [DATA_WIDTH:0] d_wrap_s;
  logic [DATA_WIDTH-1:0]      d_next;
  logic [1:0]                 cls_next;

  logic [DATA_WIDTH-1:0] acc_s1_reg;
  logic [DATA_WIDTH-1:0] r0_s1_reg;
  logic [DATA_WIDTH-1:0] d_s1_reg;
  logic [1:0]            cls_s1_reg;

  logic [DATA_WIDTH-1:0] acc1;
  logic [DATA_WIDTH-1:0] r1m;
  logic [1:0]            cls_s2_reg;

  logic [1:0]            sgn_reg;
  logic [1:0]            sgn_next;

  assign en        = !v_reg[STAGES-1] || out_ready;
  assign in_ready  = en;
  assign out_valid = v_reg[STAGES-1];
  assign tag_out   = tag_reg[STAGES-1];
  assign sgn_out   = sgn_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      v_reg[0]   <= 1'b0;
      tag_reg[0] <= '0;
    end else if (en) begin
      v_reg[0]   <= in_valid;
      tag_reg[0] <= tag_in;
    end
  end

  for (genvar gi = 1; gi < STAGES; gi++) begin : g_chain
    always_ff @(posedge clk) begin
      if (reset) begin
        v_reg[gi]   <= 1'b0;
        tag_reg[gi] <= '0;
      end else if (en) begin
        v_reg[gi]   <= v_reg[gi-1];
        tag_reg[gi] <= tag_reg[gi-1];
      end
    end
  end

  // Signed difference wraps back into [0, MOD_R1) with a single conditional add.
  assign diff_s   = $signed({1'b0, dig_r1}) - $signed({1'b0, dig_r0});
  assign d_wrap_s = diff_s[DATA_WIDTH] ? diff_s + $signed((DATA_WIDTH+1)'(MOD_R1)) : diff_s;
  assign d_next   = d_wrap_s[DATA_WIDTH-1:0];

  // Upstream error forces error; upstream negative is only consistent with an all-ones top digit.
  always_comb begin
    cls_next = SGN_ERR;
    if (sgn_in == SGN_ERR) begin
      cls_next = SGN_ERR;
    end else if (sgn_in == SGN_NEG && dig_r0 != DATA_WIDTH'(MOD_R0 - 1)) begin
      cls_next = SGN_ERR;
    end else if (sgn_in == SGN_ZERO && dig_r0 == '0) begin
      cls_next = SGN_ZERO;
    end else if (dig_r0 <= DATA_WIDTH'(POS_TH)) begin
      cls_next = SGN_POS;
    end else if (dig_r0 >= DATA_WIDTH'(NEG_TH)) begin
      cls_next = SGN_NEG;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_s1_reg <= '0;
      r0_s1_reg  <= '0;
      d_s1_reg   <= '0;
      cls_s1_reg <= SGN_ZERO;
    end else if (en) begin
      acc_s1_reg <= acc_in;
      r0_s1_reg  <= dig_r0;
      d_s1_reg   <= d_next;
      cls_s1_reg <= cls_next;
    end
  end

  mrc_modmac_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .MOD        (MOD_ACC)
  ) u_acc1 (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .a     (r0_s1_reg),
    .b     (DATA_WIDTH'(PWR_R0)),
    .c     (acc_s1_reg),
    .q     (acc1)
  );

  mrc_modmac_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .MOD        (MOD_R1)
  ) u_r1m (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .a     (d_s1_reg),
    .b     (DATA_WIDTH'(INV)),
    .c     ('0),
    .q     (r1m)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cls_s2_reg <= SGN_ZERO;
    end else if (en) begin
      cls_s2_reg <= cls_s1_reg;
    end
  end

  mrc_modmac_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .MOD        (MOD_ACC)
  ) u_acc_out (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .a     (r1m),
    .b     (DATA_WIDTH'(PWR_R1)),
    .c     (acc1),
    .q     (acc_out)
  );

  // The redundant digit must be 0 for non-negative values and all-ones for negative ones.
  always_comb begin
    sgn_next = SGN_ERR;
    if (r1m == '0 && (cls_s2_reg == SGN_ZERO || cls_s2_reg == SGN_POS)) begin
      sgn_next = cls_s2_reg;
    end else if (r1m == DATA_WIDTH'(MOD_R1 - 1) && cls_s2_reg == SGN_NEG) begin
      sgn_next = cls_s2_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sgn_reg <= SGN_ZERO;
    end else if (en) begin
      sgn_reg <= sgn_next;
    end
  end

endmodule

// File: tb/tb_mrc_ec_tail_pipe.sv
// Scoreboard bench for mrc_ec_tail_pipe on the small moduli set (37/41/43, INV=21).
module tb_mrc_ec_tail_pipe;

  localparam int DW = 6;
  localparam int TW = 8;

  typedef struct {
    logic [DW-1:0] acc;
    logic [1:0]    sgn;
    logic [TW-1:0] tag;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] acc_in;
  logic [DW-1:0] dig_r0;
  logic [DW-1:0] dig_r1;
  logic [1:0]    sgn_in;
  logic [TW-1:0] tag_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] acc_out;
  logic [1:0]    sgn_out;
  logic [TW-1:0] tag_out;

  int   checks;
  int   errors;
  int   pop_count;
  exp_t sb_q[$];

  mrc_ec_tail_pipe #(
    .DATA_WIDTH (DW),
    .TAG_WIDTH  (TW),
    .MOD_ACC    (37),
    .MOD_R0     (41),
    .MOD_R1     (43),
    .PWR_R0     (2),
    .PWR_R1     (3),
    .POS_TH     (20),
    .NEG_TH     (21)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .acc_in    (acc_in),
    .dig_r0    (dig_r0),
    .dig_r1    (dig_r1),
    .sgn_in    (sgn_in),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .sgn_out   (sgn_out),
    .tag_out   (tag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model written directly from the arithmetic definition.
  function automatic exp_t model(input int a, input int r0, input int r1,
                                 input int s, input int t);
    exp_t e;
    int   r1m;
    int   cls;
    int   sg;
    r1m = (((r1 - r0 + 43) % 43) * 21) % 43;
    if (s == 3)                     cls = 3;
    else if (s == 2 && r0 != 40)    cls = 3;
    else if (s == 0 && r0 == 0)     cls = 0;
    else if (r0 <= 20)              cls = 1;
    else if (r0 >= 21)              cls = 2;
    else                            cls = 3;
    if (r1m == 0 && (cls == 0 || cls == 1)) sg = cls;
    else if (r1m == 42 && cls == 2)         sg = cls;
    else                                    sg = 3;
    e.acc = DW'((a + r0 * 2 + r1m * 3) % 37);
    e.sgn = 2'(sg);
    e.tag = TW'(t);
    return e;
  endfunction

  // One clock: scoreboard pops/pushes on the falling edge, then return just after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (reset) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got tag=%0d acc=%0d sgn=%0d, required no output",
                   tag_out, acc_out, sgn_out);
        end else begin
          e = sb_q.pop_front();
          pop_count++;
          if (acc_out !== e.acc || sgn_out !== e.sgn || tag_out !== e.tag) begin
            errors++;
            $display("FAIL sb_out: got tag=%0d acc=%0d sgn=%0d, required tag=%0d acc=%0d sgn=%0d",
                     tag_out, acc_out, sgn_out, e.tag, e.acc, e.sgn);
          end else begin
            $display("OUT tag=%0d acc=%0d sgn=%0d", tag_out, acc_out, sgn_out);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(model(int'(acc_in), int'(dig_r0), int'(dig_r1), int'(sgn_in), int'(tag_in)));
        $display("IN  tag=%0d acc=%0d r0=%0d r1=%0d sgn=%0d", tag_in, acc_in, dig_r0, dig_r1, sgn_in);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int a, input int r0, input int r1, input int s, input int t);
    acc_in   = DW'(a);
    dig_r0   = DW'(r0);
    dig_r1   = DW'(r1);
    sgn_in   = 2'(s);
    tag_in   = TW'(t);
    in_valid = 1'b1;
  endtask

  task automatic set_random_beat(input int t);
    int r0;
    r0 = $urandom_range(0, 40);
    set_beat($urandom_range(0, 36), r0,
             ($urandom_range(0, 1) == 1) ? r0 : $urandom_range(0, 42),
             $urandom_range(0, 3), t);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
    checks++; if (acc_out !== 6'd0)   begin errors++; $display("FAIL reset_acc_out: got %0d required 0", acc_out); end
    checks++; if (sgn_out !== 2'b00)  begin errors++; $display("FAIL reset_sgn_out: got %0d required 0", sgn_out); end
    checks++; if (tag_out !== 8'd0)   begin errors++; $display("FAIL reset_tag_out: got %0d required 0", tag_out); end
  endtask

  task automatic test_vectors();
    int va [4] = '{5, 5, 0, 0};
    int vr0[4] = '{0, 3, 30, 30};
    int vr1[4] = '{0, 3, 32, 5};
    int vs [4] = '{0, 1, 0, 0};
    int ea [4] = '{5, 11, 1, 14};
    int es [4] = '{0, 1, 2, 3};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_beat(va[i], vr0[i], vr1[i], vs[i], i + 1);
      tick();
      in_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL vec%0d_early_valid: got %0b required 0", i, out_valid); end
      tick();
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL vec%0d_latency: got out_valid=%0b required 1", i, out_valid); end
      checks++;
      if (acc_out !== DW'(ea[i])) begin errors++; $display("FAIL vec%0d_acc: got %0d required %0d", i, acc_out, ea[i]); end
      checks++;
      if (sgn_out !== 2'(es[i])) begin errors++; $display("FAIL vec%0d_sgn: got %0d required %0d", i, sgn_out, es[i]); end
      checks++;
      if (tag_out !== TW'(i + 1)) begin errors++; $display("FAIL vec%0d_tag: got %0d required %0d", i, tag_out, i + 1); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int run;
    int max_run;
    int base;
    run     = 0;
    max_run = 0;
    base    = pop_count;
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i < 8) begin
        set_random_beat(32 + i);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready%0d: got %0b required 1", i, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (out_valid === 1'b1) run++;
      else begin
        if (run > max_run) max_run = run;
        run = 0;
      end
    end
    if (run > max_run) max_run = run;
    checks++;
    if (max_run != 8) begin errors++; $display("FAIL b2b_consecutive: got run %0d required 8", max_run); end
    checks++;
    if (pop_count - base != 8) begin errors++; $display("FAIL b2b_count: got %0d beats required 8", pop_count - base); end
  endtask

  task automatic test_stall();
    int base;
    base = pop_count;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_random_beat(64 + i);
      tick();
    end
    set_beat(1, 1, 1, 1, 79);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready%0d: got %0b required 0", k, in_ready); end
      checks++;
      if (sb_q.size() != 3) begin
        errors++;
        $display("FAIL stall_queue%0d: got %0d pending required 3", k, sb_q.size());
      end else if (out_valid !== 1'b1 || acc_out !== sb_q[0].acc || sgn_out !== sb_q[0].sgn ||
                   tag_out !== sb_q[0].tag) begin
        errors++;
        $display("FAIL stall_hold%0d: got v=%0b acc=%0d sgn=%0d tag=%0d required v=1 acc=%0d sgn=%0d tag=%0d",
                 k, out_valid, acc_out, sgn_out, tag_out, sb_q[0].acc, sb_q[0].sgn, sb_q[0].tag);
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10 && sb_q.size() != 0; k++) tick();
    for (int k = 0; k < 3; k++) tick();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL stall_drain_timeout: got %0d pending required 0", sb_q.size()); end
    checks++;
    if (pop_count - base != 3) begin errors++; $display("FAIL stall_count: got %0d beats required 3", pop_count - base); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    set_random_beat(96);
    tick();
    set_random_beat(97);
    tick();
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %0b required 0", out_valid); end
    checks++; if (acc_out !== 6'd0)   begin errors++; $display("FAIL rst_mid_acc: got %0d required 0", acc_out); end
    checks++; if (sgn_out !== 2'b00)  begin errors++; $display("FAIL rst_mid_sgn: got %0d required 0", sgn_out); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_mid_in_ready: got %0b required 1", in_ready); end
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_stale%0d: got out_valid=%0b required 0", k, out_valid); end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    pop_count = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    acc_in    = '0;
    dig_r0    = '0;
    dig_r1    = '0;
    sgn_in    = '0;
    tag_in    = '0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
